// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control unit: sequences FETCH/DECODE/EXE/MEM/WB from the
// latched opcode/funct and drives ALU op, mux selects, write enables and a retired counter.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src_b,
    output logic [1:0]  ext_op,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_we,
    output logic        instr_done,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);
    // state   | meaning
    // FETCH   | IR and PC+4 written
    // DECODE  | operands latched; jumps / jr / unsupported retire here
    // EXE     | ALU op per instruction; beq retires here
    // MEM     | sw write or lw read
    // WB      | register-file write
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;

    state_t cur, nxt;

    logic is_r, is_addu, is_subu, is_and, is_sll, is_jr;
    logic is_j, is_jal, is_beq, is_ori, is_lui, is_lw, is_sw;
    logic is_r_alu, supported;

    logic pc_we_c, ir_we_c, rf_we_c, mem_we_c, done_c;

    assign is_r      = (opcode == OP_RTYPE);
    assign is_addu   = is_r && (funct == FN_ADDU);
    assign is_subu   = is_r && (funct == FN_SUBU);
    assign is_and    = is_r && (funct == FN_AND);
    assign is_sll    = is_r && (funct == FN_SLL);
    assign is_jr     = is_r && (funct == FN_JR);
    assign is_j      = (opcode == OP_J);
    assign is_jal    = (opcode == OP_JAL);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_ori    = (opcode == OP_ORI);
    assign is_lui    = (opcode == OP_LUI);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_r_alu  = is_addu || is_subu || is_and || is_sll;
    assign supported = is_r_alu || is_beq || is_ori || is_lui || is_lw || is_sw;

    always_comb begin
        nxt        = S_FETCH;
        alu_op     = 4'd2;
        alu_src_b  = 1'b0;
        ext_op     = 2'd0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        pc_src     = 2'd0;
        pc_we_c    = 1'b0;
        ir_we_c    = 1'b0;
        rf_we_c    = 1'b0;
        mem_we_c   = 1'b0;
        done_c     = 1'b0;
        case (cur)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                nxt     = S_DECODE;
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_we_c = 1'b1;
                    pc_src  = 2'd2;
                    done_c  = 1'b1;
                    if (is_jal) begin
                        rf_we_c    = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_we_c = 1'b1;
                    pc_src  = 2'd3;
                    done_c  = 1'b1;
                end else if (!supported) begin
                    done_c = 1'b1;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                nxt = S_WB;
                if (is_addu) alu_op = 4'd2;
                else if (is_subu) alu_op = 4'd3;
                else if (is_and) alu_op = 4'd1;
                else if (is_sll) alu_op = 4'd5;
                else if (is_ori) begin
                    alu_op    = 4'd0;
                    alu_src_b = 1'b1;
                end else if (is_lui) begin
                    alu_op    = 4'd6;
                    alu_src_b = 1'b1;
                    ext_op    = 2'd2;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 1'b1;
                    ext_op    = 2'd1;
                    nxt       = S_MEM;
                end else if (is_beq) begin
                    // branch outcome depends on the live zero flag
                    alu_op  = 4'd3;
                    ext_op  = 2'd1;
                    pc_we_c = zero;
                    pc_src  = 2'd1;
                    done_c  = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_we_c = 1'b1;
                    done_c   = 1'b1;
                end else begin
                    nxt = S_WB;
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                done_c     = 1'b1;
                reg_dst    = is_r ? 2'd1 : 2'd0;
                mem_to_reg = is_lw ? 2'd1 : 2'd0;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // reset suppresses every side effect of the cycle it lands in
    assign pc_we      = pc_we_c  & ~reset;
    assign ir_we      = ir_we_c  & ~reset;
    assign rf_we      = rf_we_c  & ~reset;
    assign mem_we     = mem_we_c & ~reset;
    assign instr_done = done_c   & ~reset;
    assign state      = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_FETCH;
            instr_cnt <= 32'd0;
        end else begin
            cur <= nxt;
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
        end
    end
endmodule
